// File: rtl/bar_spectrum_renderer.sv
// Per-pixel renderer for an N-bar spectrum display with per-bar peak-hold markers.
// Heights, peaks and mode are latched per frame; RGB is registered with one cycle of latency.
module bar_spectrum_renderer #(
  parameter int unsigned NUM_BARS   = 10,
  parameter int unsigned AMP_W      = 24,
  parameter int unsigned AMP_SHIFT  = 14,
  parameter int unsigned BAR_X0     = 10,
  parameter int unsigned BAR_WIDTH  = 53,
  parameter int unsigned BAR_GAP    = 10,
  parameter int unsigned SCREEN_H   = 480,
  parameter int unsigned PEAK_HOLD  = 30,
  parameter int unsigned PEAK_DECAY = 2,
  parameter int unsigned PEAK_THICK = 3
) (
  input  logic                      Clk,
  input  logic                      Reset_n,
  input  logic                      frame_start,
  input  logic [NUM_BARS*AMP_W-1:0] amp_in,
  input  logic [1:0]                mode_in,
  input  logic [9:0]                DrawX,
  input  logic [9:0]                DrawY,
  output logic [7:0]                Red,
  output logic [7:0]                Green,
  output logic [7:0]                Blue,
  output logic                      frame_done
);

  localparam int unsigned HoldW   = (PEAK_HOLD > 0) ? $clog2(PEAK_HOLD + 1) : 1;
  localparam int          ScreenH = int'(SCREEN_H);
  localparam int          Pitch   = int'(BAR_WIDTH + BAR_GAP);

  logic [9:0]       h_q    [NUM_BARS];
  logic [9:0]       h_d    [NUM_BARS];
  logic [9:0]       pk_q   [NUM_BARS];
  logic [9:0]       pk_d   [NUM_BARS];
  logic [HoldW-1:0] hold_q [NUM_BARS];
  logic [HoldW-1:0] hold_d [NUM_BARS];
  logic [1:0]       mode_q, mode_d;
  logic             frame_done_q, frame_done_d;
  logic [23:0]      rgb_q, rgb_d;

  // Anything at or beyond the screen height (including discarded upper bits) saturates.
  function automatic logic [9:0] sat_height(input logic [AMP_W-1:0] amp);
    logic [AMP_W-1:0] sh;
    sh = amp >> AMP_SHIFT;
    if (sh >= AMP_W'(SCREEN_H)) return 10'(SCREEN_H);
    return sh[9:0];
  endfunction

  function automatic logic [9:0] decay_peak(input logic [9:0] pk, input logic [9:0] h);
    logic [9:0] dec;
    dec = (pk > 10'(PEAK_DECAY)) ? pk - 10'(PEAK_DECAY) : 10'd0;
    return (dec > h) ? dec : h;
  endfunction

  always_comb begin
    h_d          = h_q;
    pk_d         = pk_q;
    hold_d       = hold_q;
    mode_d       = mode_q;
    frame_done_d = frame_start;
    if (frame_start) begin
      mode_d = mode_in;
      for (int i = 0; i < int'(NUM_BARS); i++) begin
        h_d[i] = sat_height(amp_in[i*AMP_W +: AMP_W]);
        if (h_d[i] >= pk_q[i]) begin
          pk_d[i]   = h_d[i];
          hold_d[i] = HoldW'(PEAK_HOLD);
        end else if (hold_q[i] != '0) begin
          hold_d[i] = hold_q[i] - HoldW'(1);
        end else begin
          pk_d[i] = decay_peak(pk_q[i], h_d[i]);
        end
      end
    end
  end

  int   xi, yi, g;
  logic hit_fill, hit_peak;

  always_comb begin
    xi       = int'(DrawX);
    yi       = int'(DrawY);
    g        = 0;
    hit_fill = 1'b0;
    hit_peak = 1'b0;
    for (int i = 0; i < int'(NUM_BARS); i++) begin
      if (xi >= int'(BAR_X0) + i * Pitch && xi < int'(BAR_X0) + i * Pitch + int'(BAR_WIDTH)
          && yi < ScreenH) begin
        if (yi >= ScreenH - int'(h_q[i])) hit_fill = 1'b1;
        if (pk_q[i] != 10'd0 && yi >= ScreenH - int'(pk_q[i])
            && yi < ScreenH - int'(pk_q[i]) + int'(PEAK_THICK)) hit_peak = 1'b1;
      end
    end
    if (hit_peak && mode_q != 2'b00) begin
      rgb_d = 24'hFFFFFF;
    end else if (hit_fill && mode_q != 2'b11) begin
      if (mode_q == 2'b10) begin
        g     = 32 + ((ScreenH - 1 - yi) / 2);
        rgb_d = {8'hFF, (g > 255) ? 8'hFF : g[7:0], 8'h00};
      end else begin
        rgb_d = 24'hFF5500;
      end
    end else begin
      rgb_d = {16'h0000, 8'h7F - {1'b0, DrawX[9:3]}};
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      for (int i = 0; i < int'(NUM_BARS); i++) begin
        h_q[i]    <= '0;
        pk_q[i]   <= '0;
        hold_q[i] <= '0;
      end
      mode_q       <= '0;
      frame_done_q <= 1'b0;
      rgb_q        <= '0;
    end else begin
      h_q          <= h_d;
      pk_q         <= pk_d;
      hold_q       <= hold_d;
      mode_q       <= mode_d;
      frame_done_q <= frame_done_d;
      rgb_q        <= rgb_d;
    end
  end

  assign Red        = rgb_q[23:16];
  assign Green      = rgb_q[15:8];
  assign Blue       = rgb_q[7:0];
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_bar_spectrum_renderer.sv
// Self-checking bench for bar_spectrum_renderer: vector table, hand-written peak/reset
// sequences, and randomized frames against an arithmetic reference model.
module tb_bar_spectrum_renderer;

  localparam int NB = 10;
  localparam int AW = 24;
  localparam int X0 = 10;
  localparam int BW = 53;
  localparam int BG = 10;
  localparam int SH = 480;
  localparam int PT = 3;

  logic           Clk = 1'b0;
  logic           Reset_n = 1'b0;
  logic           frame_start = 1'b0;
  logic [NB*AW-1:0] amp_in = '0;
  logic [1:0]     mode_in = 2'b00;
  logic [9:0]     DrawX = '0, DrawY = '0;
  logic [7:0]     Red, Green, Blue;
  logic           frame_done;

  bar_spectrum_renderer dut (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .frame_start(frame_start),
    .amp_in     (amp_in),
    .mode_in    (mode_in),
    .DrawX      (DrawX),
    .DrawY      (DrawY),
    .Red        (Red),
    .Green      (Green),
    .Blue       (Blue),
    .frame_done (frame_done)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;

  logic [23:0] amps [NB];
  int m_h [NB];
  int m_pk [NB];
  int m_hold [NB];
  int m_mode;

  function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NB; i++) begin
      m_h[i] = 0; m_pk[i] = 0; m_hold[i] = 0;
    end
    m_mode = 0;
  endtask

  task automatic model_frame(input int mode);
    int h;
    for (int i = 0; i < NB; i++) begin
      h = int'(amps[i]) / (1 << 14);
      if (h > SH) h = SH;
      if (h >= m_pk[i]) begin
        m_pk[i] = h; m_hold[i] = 30;
      end else if (m_hold[i] > 0) begin
        m_hold[i]--;
      end else begin
        m_pk[i] = (m_pk[i] - 2 > h) ? m_pk[i] - 2 : h;
      end
      m_h[i] = h;
    end
    m_mode = mode;
  endtask

  function automatic logic [23:0] ref_pixel(input int x, input int y);
    int k, off, g;
    bit in_bar, fill, peak;
    k = 0; in_bar = 0;
    if (x >= X0) begin
      k = (x - X0) / (BW + BG);
      off = (x - X0) % (BW + BG);
      in_bar = (k < NB) && (off < BW);
      if (!in_bar) k = 0;
    end
    fill = in_bar && y < SH && y >= SH - m_h[k];
    peak = in_bar && m_pk[k] > 0 && y < SH && y >= SH - m_pk[k] && y < SH - m_pk[k] + PT;
    if (peak && m_mode != 0) return 24'hFFFFFF;
    if (fill && m_mode != 3) begin
      if (m_mode == 2) begin
        g = 32 + (SH - 1 - y) / 2;
        if (g > 255) g = 255;
        return {8'hFF, 8'(g), 8'h00};
      end
      return 24'hFF5500;
    end
    return {16'h0000, 8'(127 - x / 8)};
  endfunction

  task automatic drive_amps();
    for (int i = 0; i < NB; i++) amp_in[i*AW +: AW] = amps[i];
  endtask

  task automatic set_amp0(input logic [23:0] a);
    for (int i = 0; i < NB; i++) amps[i] = '0;
    amps[0] = a;
  endtask

  task automatic do_frame(input int mode);
    @(negedge Clk);
    drive_amps();
    mode_in = 2'(mode);
    frame_start = 1'b1;
    @(posedge Clk); #1;
    model_frame(mode);
    chk("frame_done_pulse", {31'b0, frame_done}, 32'd1);
    @(negedge Clk);
    frame_start = 1'b0;
    @(posedge Clk); #1;
    chk("frame_done_single", {31'b0, frame_done}, 32'd0);
  endtask

  task automatic px(input string name, input int x, input int y, input logic [23:0] exp);
    @(negedge Clk);
    DrawX = 10'(x); DrawY = 10'(y);
    @(posedge Clk); #1;
    chk(name, {8'h00, Red, Green, Blue}, {8'h00, exp});
  endtask

  task automatic pxm(input string name, input int x, input int y);
    px(name, x, y, ref_pixel(x, y));
  endtask

  typedef struct {
    logic [23:0] amp0;
    int          mode;
    int          x;
    int          y;
    logic [23:0] exp;
  } vec_t;

  vec_t vecs [12];

  initial begin
    vecs[0]  = '{24'h190000, 0,  10, 380, 24'hFF5500};
    vecs[1]  = '{24'h190000, 0,  10, 379, 24'h00007E};
    vecs[2]  = '{24'h190000, 0,  63, 470, 24'h000078};
    vecs[3]  = '{24'h190000, 0,   9, 470, 24'h00007E};
    vecs[4]  = '{24'hFFFFFF, 0,  20,   0, 24'hFF5500};
    vecs[5]  = '{24'hFFFFFF, 0,  20, 480, 24'h00007D};
    vecs[6]  = '{24'h190000, 2,  10, 400, 24'hFF4700};
    vecs[7]  = '{24'h190000, 2,  10,   0, 24'hFFFFFF};
    vecs[8]  = '{24'h190000, 3,  10, 400, 24'h00007E};
    vecs[9]  = '{24'hFFFFFF, 2,  10, 479, 24'hFF2000};
    vecs[10] = '{24'hFFFFFF, 2,  10,  10, 24'hFFFF00};
    vecs[11] = '{24'h000000, 0, 700, 100, 24'h000028};

    model_reset();
    for (int i = 0; i < NB; i++) amps[i] = '0;
    repeat (3) @(posedge Clk);
    #1;
    chk("reset_rgb", {8'h00, Red, Green, Blue}, 32'd0);
    chk("reset_done", {31'b0, frame_done}, 32'd0);
    @(negedge Clk);
    Reset_n = 1'b1;
    px("bg_after_reset", 0, 0, 24'h00007F);

    // Vector table: one frame per entry, then one pixel.
    for (int v = 0; v < 12; v++) begin
      set_amp0(vecs[v].amp0);
      do_frame(vecs[v].mode);
      px($sformatf("vec%0d", v), vecs[v].x, vecs[v].y, vecs[v].exp);
    end

    // Reset mid-frame with a coincident frame_start.
    set_amp0(24'h190000);
    do_frame(0);
    px("pre_reset_fill", 10, 400, 24'hFF5500);
    @(negedge Clk);
    Reset_n = 1'b0; frame_start = 1'b1;
    @(posedge Clk); #1;
    chk("midreset_rgb", {8'h00, Red, Green, Blue}, 32'd0);
    chk("midreset_done", {31'b0, frame_done}, 32'd0);
    @(negedge Clk);
    Reset_n = 1'b1; frame_start = 1'b0;
    model_reset();
    @(posedge Clk); #1;
    chk("post_reset_cleared", {8'h00, Red, Green, Blue}, 32'h00007E);
    chk("post_reset_done", {31'b0, frame_done}, 32'd0);

    // Peak hold then linear decay to zero.
    set_amp0(24'(200 << 14));
    do_frame(1);
    set_amp0('0);
    for (int f = 1; f <= 130; f++) begin
      do_frame(1);
      if (m_pk[0] > 0) pxm("decay_marker", 10, SH - m_pk[0]);
      if (f == 30) px("hold_end", 10, 280, 24'hFFFFFF);
      if (f == 31) begin
        px("decay_left", 10, 280, 24'h00007E);
        px("decay_moved", 10, 282, 24'hFFFFFF);
      end
    end
    px("peak_gone", 10, 478, 24'h00007E);
    px("peak_gone_bot", 10, 479, 24'h00007E);

    // Rise during decay, then equal height reloads the hold.
    set_amp0(24'(200 << 14));
    do_frame(1);
    set_amp0('0);
    repeat (55) do_frame(1);
    chk("model_pk150", 32'(m_pk[0]), 32'd150);
    set_amp0(24'(160 << 14));
    do_frame(1);
    px("rise_pk160", 10, 320, 24'hFFFFFF);
    set_amp0('0);
    repeat (29) do_frame(1);
    set_amp0(24'(160 << 14));
    do_frame(1);
    set_amp0('0);
    repeat (30) do_frame(1);
    px("equal_reload_hold", 10, 320, 24'hFFFFFF);
    do_frame(1);
    px("equal_then_decay_old", 10, 320, 24'h00007E);
    px("equal_then_decay_new", 10, 322, 24'hFFFFFF);

    // Mode change mid-frame stays invisible until frame_start.
    set_amp0(24'h190000);
    do_frame(1);
    px("mode01_fill", 10, 400, 24'hFF5500);
    @(negedge Clk);
    mode_in = 2'b11;
    px("mode_change_hidden", 10, 400, 24'hFF5500);
    do_frame(3);
    px("mode11_nofill", 10, 400, 24'h00007E);
    px("mode11_peak", 10, 326, 24'hFFFFFF);

    // Back-to-back frame_start: each pulse is a full update.
    @(negedge Clk);
    drive_amps(); mode_in = 2'b11; frame_start = 1'b1;
    @(posedge Clk); #1;
    model_frame(3);
    chk("b2b_done0", {31'b0, frame_done}, 32'd1);
    @(posedge Clk); #1;
    model_frame(3);
    chk("b2b_done1", {31'b0, frame_done}, 32'd1);
    @(negedge Clk);
    frame_start = 1'b0;
    @(posedge Clk); #1;
    chk("b2b_done_end", {31'b0, frame_done}, 32'd0);
    pxm("b2b_peak", 10, SH - m_pk[0]);

    // Randomized frames against the reference model.
    for (int r = 0; r < 150; r++) begin
      for (int i = 0; i < NB; i++) begin
        case ($urandom_range(0, 3))
          0: amps[i] = '0;
          1: amps[i] = 24'($urandom_range(0, 480 << 14));
          2: amps[i] = 24'($urandom());
          default: amps[i] = 24'($urandom_range(0, 520) << 14);
        endcase
      end
      do_frame(int'($urandom_range(0, 3)));
      for (int p = 0; p < 6; p++) begin
        int x, y, k;
        if (p < 3) begin
          k = int'($urandom_range(0, NB - 1));
          x = X0 + k * (BW + BG) + int'($urandom_range(0, BW - 1));
          y = (p == 0) ? SH - m_pk[k] + int'($urandom_range(0, 3))
                       : int'($urandom_range(0, SH));
          if (y > 1023) y = 1023;
        end else begin
          x = int'($urandom_range(0, 1023));
          y = int'($urandom_range(0, 1023));
        end
        pxm("random_pixel", x, y);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
